// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the stream FIFO family.
// Holds the count-width helper and the default almost-full/almost-empty thresholds.
package fifo_pkg;

    // Default almost_empty threshold: flag when at most one word remains.
    localparam int AE_LEVEL_DEFAULT = 1;

    // Default almost_full margin below capacity: flag one word before full.
    localparam int AF_MARGIN_DEFAULT = 1;

    // Width of an occupancy counter that must represent 0 .. 2**depth inclusive.
    function automatic int cnt_width(input int depth);
        return depth + 1;
    endfunction

    // Default almost_full threshold for a FIFO with 2**depth words of capacity.
    function automatic int af_level_default(input int depth);
        return (1 << depth) - AF_MARGIN_DEFAULT;
    endfunction

endpackage

// File: rtl/dual_port_bram.sv
// Simple dual-port RAM: one write port, one read port with a registered
// (1-cycle) read. A read and write to the same address in one cycle
// returns the old contents.
module dual_port_bram #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             we,
    input  logic [DEPTH-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [DEPTH-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH];
    logic [WIDTH-1:0] rdata_d;
    logic [WIDTH-1:0] rdata_q;

    // Select the addressed word ahead of the read register.
    always_comb begin
        rdata_d = mem[raddr];
    end

    // Write port and registered read port share the same clock edge.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata_q <= rdata_d;
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO built from a registered-read RAM plus
// an output register. Total capacity is 2**DEPTH words, counting the word
// held in the output register.
// Optional feature: define STREAM_FIFO_ERR_EN to add sticky
// err_overflow / err_underflow flags.
module stream_fifo
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 4,
    parameter int AF_LEVEL = af_level_default(DEPTH),
    parameter int AE_LEVEL = AE_LEVEL_DEFAULT
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic                          almost_full,
    output logic                          almost_empty
`ifdef STREAM_FIFO_ERR_EN
    ,
    output logic                          err_overflow,
    output logic                          err_underflow
`endif
);

    localparam int CW = cnt_width(DEPTH);
    localparam logic [CW-1:0] CAP  = CW'(1 << DEPTH);
    localparam logic [CW-1:0] AF_L = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L = CW'(AE_LEVEL);

    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             af_q, af_d;
    logic             ae_q, ae_d;
    logic             ready_en_q, ready_en_d;
    logic             fwd_sel_q, fwd_sel_d;
    logic [WIDTH-1:0] fwd_data_q, fwd_data_d;

    logic             wr_fire;
    logic             rd_fire;
    logic             need_head;
    logic             pop;
    logic             bypass;
    logic             ram_we;
    logic [CW-1:0]    ram_count;
    logic [WIDTH-1:0] ram_rdata;
    logic [WIDTH-1:0] ram_head;

    // The RAM read address follows the next read pointer, so its registered
    // output always shows the current RAM head one cycle later.
    dual_port_bram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (aclk),
        .we    (ram_we),
        .waddr (wr_ptr_q),
        .wdata (in_data),
        .raddr (rd_ptr_d),
        .rdata (ram_rdata)
    );

    // Handshake decode: decide whether the head refills from RAM, from the
    // incoming word directly, or not at all, and whether the write lands in RAM.
    always_comb begin
        in_ready  = ready_en_q && (count_q < CAP) && !flush;
        wr_fire   = in_valid && in_ready;
        rd_fire   = out_valid_q && out_ready;
        ram_count = count_q - CW'(out_valid_q);
        need_head = !out_valid_q || rd_fire;
        pop       = need_head && (ram_count != '0);
        bypass    = need_head && (ram_count == '0) && wr_fire;
        ram_we    = wr_fire && !bypass;
        ram_head  = fwd_sel_q ? fwd_data_q : ram_rdata;
    end

    // Next-state for pointers, output stage, occupancy and threshold flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        ready_en_d  = 1'b1;
        fwd_data_d  = in_data;

        if (ram_we) begin
            wr_ptr_d = wr_ptr_q + DEPTH'(1);
        end
        if (pop) begin
            rd_ptr_d    = rd_ptr_q + DEPTH'(1);
            out_valid_d = 1'b1;
            out_data_d  = ram_head;
        end else if (bypass) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end else if (rd_fire) begin
            out_valid_d = 1'b0;
        end

        case ({wr_fire, rd_fire})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end

        fwd_sel_d = ram_we && (wr_ptr_q == rd_ptr_d);
        af_d      = (count_d >= AF_L);
        ae_d      = (count_d <= AE_L);
    end

    // State registers, cleared asynchronously while aresetn is low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            af_q        <= 1'b0;
            ae_q        <= 1'b1;
            ready_en_q  <= 1'b0;
            fwd_sel_q   <= 1'b0;
            fwd_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            af_q        <= af_d;
            ae_q        <= ae_d;
            ready_en_q  <= ready_en_d;
            fwd_sel_q   <= fwd_sel_d;
            fwd_data_q  <= fwd_data_d;
        end
    end

    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign count        = count_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef STREAM_FIFO_ERR_EN
    logic err_overflow_q, err_overflow_d;
    logic err_underflow_q, err_underflow_d;

    // Sticky protocol-error flags; a refused write in the first cycle after
    // reset release is not counted as an overflow.
    always_comb begin
        err_overflow_d  = err_overflow_q;
        err_underflow_d = err_underflow_q;
        if (flush) begin
            err_overflow_d  = 1'b0;
            err_underflow_d = 1'b0;
        end else begin
            if (in_valid && !in_ready && ready_en_q) begin
                err_overflow_d = 1'b1;
            end
            if (out_ready && !out_valid_q) begin
                err_underflow_d = 1'b1;
            end
        end
    end

    // Error flag registers.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;
`endif

endmodule

// File: doc/stream_fifo.md
STREAM_FIFO -- requirements
Module: stream_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4: address bits; capacity is 2**DEPTH words.
REQ-003 SHALL have parameter AF_LEVEL, default 2**DEPTH-1: almost_full asserts when count >= AF_LEVEL.
REQ-004 SHALL have parameter AE_LEVEL, default 1: almost_empty asserts when count <= AE_LEVEL.
REQ-005 aclk  input  1  clock; all state changes on its rising edge.
REQ-006 aresetn  input  1  reset, asynchronous, active-low.
REQ-007 flush  input  1  synchronous clear of all contents.
REQ-008 in_valid  input  1  write request; in_ready  output  1  space available; in_data  input  WIDTH  write word.
REQ-009 out_valid  output  1  head word present; out_ready  input  1  consumer accepts; out_data  output  WIDTH  head word.
REQ-010 count  output  DEPTH+1  words held, including any word in the output stage.
REQ-011 almost_full, almost_empty  output  1 each  threshold flags.

Function
REQ-012 Write SHALL fire when in_valid && in_ready; read SHALL fire when out_valid && out_ready.
REQ-013 in_ready SHALL be 1 when count < 2**DEPTH and flush is 0; it does not depend combinationally on out_ready.
REQ-014 Storage SHALL be a simple dual-port RAM with 1-cycle registered read, plus one output register.
REQ-015 First-word-fall-through: a write fired at edge N into an empty FIFO SHALL give out_valid=1 and out_data=that word from edge N onward; no read is needed.
REQ-016 When the head is consumed and RAM holds further words, the next word SHALL be valid on the cycle after the read edge; back-to-back reads SHALL sustain one word per cycle.
REQ-017 A simultaneous write and read on a FIFO holding one word SHALL present the new word next cycle with out_valid held at 1.
REQ-018 A simultaneous write and read when full SHALL not be possible, because in_ready=0; a simultaneous write and read otherwise SHALL leave count unchanged.
REQ-019 count SHALL be +1 on a write only, -1 on a read only, and unchanged on both or neither; it SHALL never exceed 2**DEPTH or wrap below 0.
REQ-020 Pointers SHALL be DEPTH bits and wrap from 2**DEPTH-1 to 0.
REQ-021 almost_full and almost_empty SHALL be registered and consistent with count in the same cycle.
REQ-022 flush SHALL, at the edge it is sampled high, zero the pointers and count and set out_valid=0; any write or read in that cycle is discarded.
REQ-023 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-024 On aresetn low: in_ready=0, out_valid=0, count=0, almost_full=0, almost_empty=1, out_data=0, pointers=0.
REQ-025 in_ready SHALL rise on the first edge after reset release.
REQ-026 Reset mid-transfer SHALL discard all contents; no partial word is presented after release.

Configuration
REQ-027 With macro STREAM_FIFO_ERR_EN defined, the block SHALL add two ports: err_overflow (output, 1 bit) and err_underflow (output, 1 bit).
REQ-028 err_overflow is sticky and SHALL set on in_valid && !in_ready (excluding flush and reset cycles).
REQ-029 err_underflow is sticky and SHALL set on out_ready && !out_valid.
REQ-030 Both error flags SHALL clear on reset or flush.
REQ-031 Without STREAM_FIFO_ERR_EN, the ports and their logic SHALL be absent, with all other behaviour identical.

Structure
REQ-032 Package fifo_pkg SHALL hold the count-width helper function and the default-threshold constants.
REQ-033 RAM SHALL be the existing dual_port_bram sub-module; all other logic SHALL be local to stream_fifo.

Verification
REQ-034 WIDTH=8, DEPTH=2: write 0x11..0x44 with out_ready=0 -> count=4, in_ready=0, almost_full=1; then 4 reads -> 0x11,0x22,0x33,0x44 in order, count=0, almost_empty=1.
REQ-035 Empty FIFO, write 0xA5 at edge N -> out_valid=1 and out_data=0xA5 after edge N; with out_ready=1 -> count=0 after N+1.
REQ-036 Continuous in_valid=out_ready=1 for 20 cycles with incrementing data -> 1 word/cycle, no gaps or reorder, count steady, pointers wrap cleanly.
REQ-037 Hold 3 words, assert flush for one cycle together with in_valid -> count=0, out_valid=0, nothing written.
REQ-038 With STREAM_FIFO_ERR_EN: write when full -> err_overflow=1 and stays 1; read when empty -> err_underflow=1; flush -> both 0.
REQ-039 Assert aresetn low while 2 words are held and a write is in flight -> all outputs match REQ-024; after release, out_valid stays 0 until a new write.
